lab4_3_gated_capture: RTL and testbench

LAB4_3_GATED_CAPTURE -- requirements
Module: lab4_3_gated_capture

---
 rtl/lab4_3_gated_capture.sv | 117 +++++++++++
 tb/tb_lab4_3_gated_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab4_3_gated_capture.sv
// Gated-source capture register with acknowledge handshake, overrun
// counting and a hold timeout. A word offered while enable is high is
// captured when the block is idle. It is held until the consumer
// acknowledges it, or until it has waited TIMEOUT cycles.
module lab4_3_gated_capture #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16   // legal range 2..255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             enable,
   input  logic             ack,
   output logic [WIDTH-1:0] y,
   output logic             valid,
   output logic [3:0]       overrun_cnt,
   output logic             timeout
);

   // Handshake: valid=1 means y carries a word the consumer has not yet
   // taken. ack is only meaningful while valid=1, and ack is ignored while
   // idle. A cycle with valid=1 and ack=1 completes the transfer. If
   // enable is also high in that cycle, the next word is loaded in the
   // same cycle, so the output goes back-to-back and valid stays high.
   // enable is a level qualifier for capture. While holding, only its
   // rising edge counts as a refused (overrun) word.

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // The counter reaches this value on the last cycle a word may wait.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [7:0]       hold_cnt_q, hold_cnt_d;
   logic [3:0]       ovr_q, ovr_d;
   logic             timeout_q, timeout_d;
   logic             valid_q, valid_d;
   logic             en_prev_q;
   logic             en_rise;

   assign en_rise = enable & ~en_prev_q;

   // Next-state logic: capture, acknowledge, overrun and timeout decisions.
   always_comb begin
      state_d    = state_q;
      y_d        = y_q;
      hold_cnt_d = hold_cnt_q;
      ovr_d      = ovr_q;
      timeout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               y_d        = data_in;
               state_d    = HOLD;
               hold_cnt_d = 8'd0;
            end
         end
         HOLD: begin
            if (ack) begin
               // Acknowledge wins over timeout on the same cycle.
               hold_cnt_d = 8'd0;
               if (enable) begin
                  y_d = data_in;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (en_rise && (ovr_q != 4'd15)) begin
                  ovr_d = ovr_q + 4'd1;
               end
               if (hold_cnt_q == LAST_CNT) begin
                  state_d    = IDLE;
                  timeout_d  = 1'b1;
                  hold_cnt_d = 8'd0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      valid_d = (state_d == HOLD);
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         y_q        <= '0;
         hold_cnt_q <= 8'd0;
         ovr_q      <= 4'd0;
         timeout_q  <= 1'b0;
         valid_q    <= 1'b0;
         en_prev_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         y_q        <= y_d;
         hold_cnt_q <= hold_cnt_d;
         ovr_q      <= ovr_d;
         timeout_q  <= timeout_d;
         valid_q    <= valid_d;
         en_prev_q  <= enable;
      end
   end

   assign y           = y_q;
   assign valid       = valid_q;
   assign overrun_cnt = ovr_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_lab4_3_gated_capture.sv
// Bench for lab4_3_gated_capture: a vector table, hand-written corner
// sequences and a random run. Every cycle is checked against a reference
// model that is kept in terms of capture time and refused-word count.
module tb_lab4_3_gated_capture;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 16;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] data_in;
   logic             enable;
   logic             ack;
   logic [WIDTH-1:0] y;
   logic             valid;
   logic [3:0]       overrun_cnt;
   logic             timeout;

   always #5 clk = ~clk;

   lab4_3_gated_capture #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .enable      (enable),
      .ack         (ack),
      .y           (y),
      .valid       (valid),
      .overrun_cnt (overrun_cnt),
      .timeout     (timeout)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   // The model tracks whether a word is held, the word itself, the cycle
   // it was taken, and the raw number of refused words. It derives the
   // outputs from those values arithmetically.
   int               m_cyc;
   logic             m_busy;
   logic [WIDTH-1:0] m_word;
   int               m_since;
   int               m_refused;
   logic             m_last_en;
   logic             m_to;

   function automatic logic [3:0] m_ovr();
      return (m_refused > 15) ? 4'd15 : 4'(m_refused);
   endfunction

   task automatic m_reset();
      m_cyc     = 0;
      m_busy    = 1'b0;
      m_word    = '0;
      m_since   = 0;
      m_refused = 0;
      m_last_en = 1'b0;
      m_to      = 1'b0;
   endtask

   task automatic m_edge(input logic en, input logic ak, input logic [WIDTH-1:0] din);
      m_cyc = m_cyc + 1;
      m_to  = 1'b0;
      if (!m_busy) begin
         if (en) begin
            m_busy  = 1'b1;
            m_word  = din;
            m_since = m_cyc;
         end
      end else if (ak) begin
         if (en) begin
            m_word  = din;
            m_since = m_cyc;
         end else begin
            m_busy = 1'b0;
         end
      end else begin
         if (en && !m_last_en) m_refused = m_refused + 1;
         if (m_cyc - m_since == TIMEOUT) begin
            m_busy = 1'b0;
            m_to   = 1'b1;
         end
      end
      m_last_en = en;
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".y"},       32'(y),           32'(m_word));
      chk({tag, ".valid"},   32'(valid),       32'(m_busy));
      chk({tag, ".overrun"}, 32'(overrun_cnt), 32'(m_ovr()));
      chk({tag, ".timeout"}, 32'(timeout),     32'(m_to));
   endtask

   // ---------------- driver ----------------
   // Inputs change 1 time unit after a rising edge. The DUT samples them at
   // the next edge, and outputs are read 1 time unit after that edge.
   task automatic cycle(input logic en, input logic ak, input logic [WIDTH-1:0] din, input string tag);
      enable  = en;
      ack     = ak;
      data_in = din;
      @(posedge clk);
      #1;
      m_edge(en, ak, din);
      chk_model(tag);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      enable  = 1'b0;
      ack     = 1'b0;
      data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic             en;
      logic             ak;
      logic [WIDTH-1:0] din;
      logic [WIDTH-1:0] exp_y;
      logic             exp_valid;
      logic [3:0]       exp_ovr;
   } vec_t;

   vec_t vecs[13];

   initial begin
      // capture / ack, ack in idle, back-to-back, three overruns, release
      vecs[0]  = '{1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1, 4'd0};
      vecs[1]  = '{1'b0, 1'b1, 8'h00, 8'hA5, 1'b0, 4'd0};
      vecs[2]  = '{1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0, 4'd0};
      vecs[3]  = '{1'b1, 1'b0, 8'h11, 8'h11, 1'b1, 4'd0};
      vecs[4]  = '{1'b1, 1'b1, 8'h22, 8'h22, 1'b1, 4'd0};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h22, 1'b1, 4'd0};
      vecs[6]  = '{1'b1, 1'b0, 8'hFF, 8'h22, 1'b1, 4'd1};
      vecs[7]  = '{1'b1, 1'b0, 8'hFF, 8'h22, 1'b1, 4'd1};
      vecs[8]  = '{1'b0, 1'b0, 8'hFF, 8'h22, 1'b1, 4'd1};
      vecs[9]  = '{1'b1, 1'b0, 8'hFF, 8'h22, 1'b1, 4'd2};
      vecs[10] = '{1'b0, 1'b0, 8'hFF, 8'h22, 1'b1, 4'd2};
      vecs[11] = '{1'b1, 1'b0, 8'hFF, 8'h22, 1'b1, 4'd3};
      vecs[12] = '{1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 4'd3};
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [WIDTH-1:0] y_keep;
      logic [3:0]       ovr_keep;
      logic [WIDTH-1:0] last_word;

      rst     = 1'b1;
      enable  = 1'b0;
      ack     = 1'b0;
      data_in = '0;
      #2;
      chk("reset.y",       32'(y),           32'd0);
      chk("reset.valid",   32'(valid),       32'd0);
      chk("reset.overrun", 32'(overrun_cnt), 32'd0);
      chk("reset.timeout", 32'(timeout),     32'd0);
      do_reset();

      // Table vectors
      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].en, vecs[i].ak, vecs[i].din, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d.y", i),       32'(y),           32'(vecs[i].exp_y));
         chk($sformatf("vec%0d.valid", i),   32'(valid),       32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d.overrun", i), 32'(overrun_cnt), 32'(vecs[i].exp_ovr));
         chk($sformatf("vec%0d.timeout", i), 32'(timeout),     32'd0);
      end

      // Timeout after TIMEOUT cycles without ack
      cycle(1'b1, 1'b0, 8'h5A, "to_cap");
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         cycle(1'b0, 1'b0, WIDTH'($urandom), "to_wait");
      end
      chk("to.valid_before", 32'(valid), 32'd1);
      cycle(1'b0, 1'b0, 8'h00, "to_fire");
      chk("to.pulse",  32'(timeout), 32'd1);
      chk("to.valid",  32'(valid),   32'd0);
      chk("to.y_kept", 32'(y),       32'h5A);
      cycle(1'b0, 1'b0, 8'h00, "to_after");
      chk("to.pulse_one_cycle", 32'(timeout), 32'd0);

      // Ack on the timeout cycle takes priority
      cycle(1'b1, 1'b0, 8'h6B, "pri_cap");
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         cycle(1'b0, 1'b0, 8'h00, "pri_wait");
      end
      cycle(1'b0, 1'b1, 8'h00, "pri_ack");
      chk("pri.no_pulse", 32'(timeout), 32'd0);
      chk("pri.valid",    32'(valid),   32'd0);

      // Overrun saturation. Every five pulses a back-to-back capture
      // restarts the hold time so the word never times out.
      cycle(1'b1, 1'b0, 8'h77, "sat_cap");
      last_word = 8'h77;
      for (int i = 0; i < 20; i++) begin
         if ((i % 5) == 4) begin
            cycle(1'b0, 1'b0, 8'h00, "sat_gap");
            last_word = 8'h80 + 8'(i);
            cycle(1'b1, 1'b1, last_word, "sat_b2b");
         end
         cycle(1'b0, 1'b0, 8'h00, "sat_low");
         cycle(1'b1, 1'b0, 8'hFF, "sat_pulse");
      end
      chk("sat.overrun", 32'(overrun_cnt), 32'd15);
      chk("sat.y",       32'(y),           32'(last_word));

      // Asynchronous reset between edges while holding
      #2;
      rst = 1'b1;
      #1;
      chk("arst.y",       32'(y),           32'd0);
      chk("arst.valid",   32'(valid),       32'd0);
      chk("arst.overrun", 32'(overrun_cnt), 32'd0);
      enable = 1'b0;
      ack    = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
      cycle(1'b0, 1'b0, 8'hEE, "arst_idle");
      chk("arst.no_capture", 32'(valid), 32'd0);

      // Idle immunity
      cycle(1'b1, 1'b0, 8'hC3, "imm_cap");
      cycle(1'b0, 1'b1, 8'h00, "imm_ack");
      y_keep   = y;
      ovr_keep = overrun_cnt;
      chk("imm.y_start", 32'(y_keep), 32'hC3);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'(i % 2), WIDTH'($urandom), "imm");
      end
      chk("imm.y",       32'(y),           32'(y_keep));
      chk("imm.valid",   32'(valid),       32'd0);
      chk("imm.overrun", 32'(overrun_cnt), 32'(ovr_keep));

      // Random traffic checked against the model
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0),
               WIDTH'($urandom), "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
